bm_multicore_nonce_scheduler: RTL and testbench
===============================================

// Module: bm_multicore_nonce_scheduler
// PURPOSE
//  Parametrised successor to the single-pipeline mining control: splits one job's nonce range across
//  NUM_CORES hash engines over per-core valid/ready request ports, checks each response hash against a
//  programmable target, and queues hits in a result FIFO for firmware. Adds thermal throttle with
//  hysteresis, job abort, hit-drop accounting and hash counting. Sits between job intake and hash cores.
// PARAMETERS
//  NUM_CORES   4    number of hash engines served (>=1); CID_W = max(1,$clog2(NUM_CORES))
//  NONCE_W     32   nonce / range width
//  CMP_W       32   width of hash bits compared against target
//  FIFO_DEPTH  8    result FIFO entries (power of 2, >=2)
//  TEMP_W      8    temperature width
//  TEMP_HI     130  throttle set when temperature > TEMP_HI
//  TEMP_LO     110  throttle clear when temperature < TEMP_LO (TEMP_LO < TEMP_HI)
// PORTS
//  clk_100m        in   1                  single clock, all logic posedge
//  reset           in   1                  synchronous, active-high
//  job_start       in   1                  1-cycle pulse; latch job inputs (honoured only in IDLE)
//  start_nonce     in   NONCE_W            first nonce of job
//  nonce_range     in   NONCE_W            number of nonces to issue (0 = empty job)
//  target          in   CMP_W              hit when hash < target (unsigned, strict)
//  job_abort       in   1                  1-cycle pulse; cancel current job
//  temperature     in   TEMP_W             die temperature, unsigned
//  core_req_valid  out  NUM_CORES          per-core request valid
//  core_req_ready  in   NUM_CORES          per-core request ready
//  core_req_nonce  out  NUM_CORES*NONCE_W  per-core nonce, core i at [i*NONCE_W +: NONCE_W]
//  core_rsp_valid  in   NUM_CORES          per-core response valid (1 cycle per accepted request)
//  core_rsp_nonce  in   NUM_CORES*NONCE_W  nonce of response
//  core_rsp_hash   in   NUM_CORES*CMP_W    compared hash bits of response
//  res_valid       out  1                  result FIFO non-empty
//  res_ready       in   1                  pop head when res_valid & res_ready
//  res_nonce       out  NONCE_W            head hit nonce
//  res_core        out  CID_W              head hit core index
//  busy            out  1                  state != IDLE
//  throttle        out  1                  thermal throttle active
//  job_done        out  1                  1-cycle pulse on job completion or abort completion
//  hash_count      out  32                 total responses received, wraps mod 2^32
//  drop_count      out  16                 hits lost (FIFO full / same-cycle collision), saturates 0xFFFF
//  state           out  2                  0 IDLE, 1 DISPATCH, 2 DRAIN
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; FIFO empty; counters 0; all request slots empty; abort flag 0.
//  IDLE: job_start -> latch nonce ptr=start_nonce, remaining=nonce_range, target; -> DISPATCH next edge.
//   job_start outside IDLE is ignored. hash_count/drop_count persist across jobs (cleared only by reset).
//  DISPATCH: per edge, if remaining!=0 and !throttle, load at most ONE empty slot (core_req_valid[i]==0),
//   chosen round-robin from rr_ptr upward; rr_ptr <- chosen+1 (mod NUM_CORES). Nonce ptr += 1 (wraps
//   mod 2^NONCE_W), remaining -= 1. First core_req_valid rises 2 cycles after job_start.
//  Slot holds valid+nonce stable until core_req_ready; on handshake slot empties, outstanding += 1.
//   A slot emptied on an edge is not reloaded until the next edge.
//  remaining==0 -> DRAIN.
//  DRAIN: no issue. When all slots empty and outstanding==0 -> job_done pulse, -> IDLE same edge.
//  Empty job (nonce_range==0): DISPATCH -> DRAIN -> job_done; pulse 3 cycles after job_start.
//  Responses (any state): hash_count += popcount(core_rsp_valid); outstanding -= popcount (floor 0;
//   accept/response same cycle both applied). Hit = rsp_valid & hash<target & !abort flag.
//  Hit push: lowest-index hit pushed per edge if FIFO not full (pop same cycle frees space); every other
//   hit that cycle, and a hit arriving while full with no pop, increments drop_count (by count, saturating).
//   Hit at cycle t with empty FIFO -> res_valid at t+1. FIFO is first-word-fall-through.
//  job_abort (DISPATCH or DRAIN): clear all slots (un-handshaken requests withdrawn), remaining=0,
//   abort flag=1, -> DRAIN; responses still counted, hits discarded; flag cleared on job_done. Ignored in IDLE.
//  job_abort and job_start same cycle in IDLE: start wins. reset mid-job: immediate return to reset state.
//  Throttle: registered; set when temperature>TEMP_HI, cleared when temperature<TEMP_LO, else hold.
//   Blocks new slot loads next edge; pending slots and responses continue.
// TESTING
//  1 reset; job start=0xFFFFFFFE range=4, cores always ready, echo rsp 3 cycles later, hash=0xFFFFFFFF ->
//    nonces FFFFFFFE,FFFFFFFF,0,1 issued round-robin cores 0..3; hash_count=4; job_done; no res_valid.
//  2 target=0x1000; core 2 returns hash 0x0FFF nonce 0x55 -> res_valid next cycle, res_nonce=0x55, res_core=2.
//  3 FIFO_DEPTH=8, res_ready=0, 10 hits on distinct cycles -> 8 queued, drop_count=2; pop all -> order kept.
//  4 cores 0,1 hit same cycle -> only core 0 queued, drop_count +1.
//  5 temperature 131 mid-job -> throttle=1, issue stops; 120 -> still 1; 109 -> 0, issue resumes, all nonces issued once.
//  6 job_abort with 2 outstanding, hit responses arrive -> no FIFO push, job_done after last response; range=0 -> job_done at +3.

Source files
------------

// File: rtl/bm_multicore_nonce_scheduler.sv
// Splits one job's nonce range across NUM_CORES hash engines, checks responses against a target,
// and queues hits in a FWFT result FIFO; adds thermal throttle, job abort and hash/drop accounting.
module bm_multicore_nonce_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int NONCE_W    = 32,
    parameter int CMP_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TEMP_W     = 8,
    parameter int TEMP_HI    = 130,
    parameter int TEMP_LO    = 110,
    localparam int CID_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                         clk_100m,
    input  logic                         reset,
    input  logic                         job_start,
    input  logic [NONCE_W-1:0]           start_nonce,
    input  logic [NONCE_W-1:0]           nonce_range,
    input  logic [CMP_W-1:0]             target,
    input  logic                         job_abort,
    input  logic [TEMP_W-1:0]            temperature,
    output logic [NUM_CORES-1:0]         core_req_valid,
    input  logic [NUM_CORES-1:0]         core_req_ready,
    output logic [NUM_CORES*NONCE_W-1:0] core_req_nonce,
    input  logic [NUM_CORES-1:0]         core_rsp_valid,
    input  logic [NUM_CORES*NONCE_W-1:0] core_rsp_nonce,
    input  logic [NUM_CORES*CMP_W-1:0]   core_rsp_hash,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [NONCE_W-1:0]           res_nonce,
    output logic [CID_W-1:0]             res_core,
    output logic                         busy,
    output logic                         throttle,
    output logic                         job_done,
    output logic [31:0]                  hash_count,
    output logic [15:0]                  drop_count,
    output logic [1:0]                   state
);
    localparam int CNT_W = $clog2(NUM_CORES + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OUT_W = 32;
    localparam logic [TEMP_W-1:0] T_HI = TEMP_W'(TEMP_HI);
    localparam logic [TEMP_W-1:0] T_LO = TEMP_W'(TEMP_LO);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CORES; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    function automatic int wrap_idx(input int base, input int k);
        return (base + k) % NUM_CORES;
    endfunction

    state_t               state_q, state_d;
    logic                 job_done_d;
    logic                 load_en, load_found;
    logic [CID_W-1:0]     load_idx, rr_ptr;
    logic [NUM_CORES-1:0] slot_valid, accepts, hit_vec;
    logic [NONCE_W-1:0]   slot_nonce [NUM_CORES];
    logic [NONCE_W-1:0]   nonce_ptr, remaining;
    logic [CMP_W-1:0]     target_q;
    logic [OUT_W-1:0]     outstanding, outstanding_d;
    logic [OUT_W:0]       out_sum;
    logic                 abort_flag, abort_hit;
    logic [CNT_W-1:0]     acc_cnt, rsp_cnt, hit_cnt, drop_inc;
    logic [CID_W-1:0]     first_hit;
    logic                 any_hit, push, pop, fifo_full;
    logic [16:0]          drop_sum;
    logic [NONCE_W-1:0]   fifo_nonce [FIFO_DEPTH];
    logic [CID_W-1:0]     fifo_core  [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          fifo_cnt;

    assign abort_hit      = job_abort && (state_q != IDLE);
    assign accepts        = slot_valid & core_req_ready;
    assign acc_cnt        = popcount(accepts);
    assign rsp_cnt        = popcount(core_rsp_valid);
    assign fifo_full      = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign res_valid      = (fifo_cnt != '0);
    assign pop            = res_valid && res_ready;
    assign res_nonce      = res_valid ? fifo_nonce[rd_ptr] : '0;
    assign res_core       = res_valid ? fifo_core[rd_ptr] : '0;
    assign core_req_valid = slot_valid;
    assign busy           = (state_q != IDLE);
    assign state          = state_q;

    always_comb begin
        core_req_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++) core_req_nonce[i*NONCE_W +: NONCE_W] = slot_nonce[i];
    end

    // Round-robin search for the first empty slot at or after rr_ptr.
    always_comb begin
        load_found = 1'b0;
        load_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!load_found && !slot_valid[wrap_idx(int'(rr_ptr), k)]) begin
                load_found = 1'b1;
                load_idx   = CID_W'(wrap_idx(int'(rr_ptr), k));
            end
        end
    end

    always_comb begin
        hit_vec   = '0;
        first_hit = '0;
        for (int i = 0; i < NUM_CORES; i++)
            hit_vec[i] = core_rsp_valid[i] && (core_rsp_hash[i*CMP_W +: CMP_W] < target_q) && !abort_flag;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (hit_vec[i]) first_hit = CID_W'(i);
        hit_cnt  = popcount(hit_vec);
        any_hit  = (hit_vec != '0);
        push     = any_hit && (!fifo_full || pop);
        drop_inc = hit_cnt - CNT_W'(push);
        drop_sum = {1'b0, drop_count} + 17'(drop_inc);
        out_sum  = {1'b0, outstanding} + (OUT_W+1)'(acc_cnt);
        if (out_sum < (OUT_W+1)'(rsp_cnt)) outstanding_d = '0;
        else                               outstanding_d = OUT_W'(out_sum - (OUT_W+1)'(rsp_cnt));
    end

    always_ff @(posedge clk_100m) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        job_done_d = 1'b0;
        load_en    = 1'b0;
        case (state_q)
            IDLE: if (job_start) state_d = DISPATCH;
            DISPATCH: begin
                if (job_abort || remaining == '0) state_d = DRAIN;
                else if (!throttle && load_found) load_en = 1'b1;
            end
            DRAIN: begin
                if (!job_abort && slot_valid == '0 && outstanding == '0) begin
                    state_d    = IDLE;
                    job_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (reset) begin
            job_done    <= 1'b0;
            slot_valid  <= '0;
            for (int i = 0; i < NUM_CORES; i++) slot_nonce[i] <= '0;
            rr_ptr      <= '0;
            nonce_ptr   <= '0;
            remaining   <= '0;
            target_q    <= '0;
            outstanding <= '0;
            abort_flag  <= 1'b0;
            throttle    <= 1'b0;
            hash_count  <= '0;
            drop_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            job_done    <= job_done_d;
            outstanding <= outstanding_d;
            hash_count  <= hash_count + 32'(rsp_cnt);
            drop_count  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            if (state_q == IDLE && job_start) begin
                nonce_ptr <= start_nonce;
                remaining <= nonce_range;
                target_q  <= target;
            end else if (abort_hit) begin
                remaining <= '0;
            end else if (load_en) begin
                nonce_ptr <= nonce_ptr + 1'b1;
                remaining <= remaining - 1'b1;
                rr_ptr    <= (int'(load_idx) == NUM_CORES - 1) ? '0 : load_idx + 1'b1;
            end

            // A slot is only loaded while empty, so load and handshake never meet on one slot.
            for (int i = 0; i < NUM_CORES; i++) begin
                if (abort_hit) begin
                    slot_valid[i] <= 1'b0;
                end else if (load_en && load_idx == CID_W'(i)) begin
                    slot_valid[i] <= 1'b1;
                    slot_nonce[i] <= nonce_ptr;
                end else if (accepts[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end

            if (abort_hit)       abort_flag <= 1'b1;
            else if (job_done_d) abort_flag <= 1'b0;

            if (temperature > T_HI)      throttle <= 1'b1;
            else if (temperature < T_LO) throttle <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; read data is gated by res_valid instead.
    always_ff @(posedge clk_100m) begin
        if (push) begin
            fifo_nonce[wr_ptr] <= core_rsp_nonce[first_hit*NONCE_W +: NONCE_W];
            fifo_core[wr_ptr]  <= first_hit;
        end
    end
endmodule

// File: tb/tb_bm_multicore_nonce_scheduler.sv
// Directed, table-driven bench for bm_multicore_nonce_scheduler with a 3-cycle echo core model.
module tb_bm_multicore_nonce_scheduler;
    localparam int NC = 4;

    logic            clk_100m = 1'b0;
    logic            reset, job_start, job_abort, res_ready;
    logic [31:0]     start_nonce, nonce_range, target;
    logic [7:0]      temperature;
    logic [NC-1:0]   core_req_valid, core_req_ready, core_rsp_valid;
    logic [NC*32-1:0] core_req_nonce, core_rsp_nonce, core_rsp_hash;
    logic            res_valid, busy, throttle, job_done;
    logic [31:0]     res_nonce, hash_count;
    logic [1:0]      res_core, state;
    logic [15:0]     drop_count;

    logic [NC-1:0]    man_valid;
    logic [NC*32-1:0] man_nonce, man_hash;
    logic             auto_echo;
    logic [31:0]      echo_hash;
    logic [NC-1:0]    pv0 = '0, pv1 = '0, pv2 = '0, hs_v;
    logic [NC*32-1:0] pn0 = '0, pn1 = '0, pn2 = '0, hs_n;
    logic [31:0]      iss_nonce[$];
    int               iss_core[$];
    logic [31:0]      exp_pop[$];
    int               checks = 0;
    int               errors = 0;
    logic [31:0]      exp_hash;
    logic [15:0]      exp_drop;
    int               n_before;

    typedef struct { int core; logic [31:0] nonce; } issue_vec_t;
    typedef struct { logic [7:0] temp; logic thr; } thr_vec_t;
    typedef struct { int core; logic [31:0] hash; logic [31:0] nonce; logic hit; } hit_vec_t;
    issue_vec_t issue_tab[4];
    thr_vec_t   thr_tab[10];
    hit_vec_t   hit_tab[5];

    bm_multicore_nonce_scheduler dut (
        .clk_100m(clk_100m), .reset(reset), .job_start(job_start), .start_nonce(start_nonce),
        .nonce_range(nonce_range), .target(target), .job_abort(job_abort), .temperature(temperature),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_nonce(core_req_nonce),
        .core_rsp_valid(core_rsp_valid), .core_rsp_nonce(core_rsp_nonce), .core_rsp_hash(core_rsp_hash),
        .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_core(res_core),
        .busy(busy), .throttle(throttle), .job_done(job_done), .hash_count(hash_count),
        .drop_count(drop_count), .state(state)
    );

    always #5 clk_100m = ~clk_100m;

    assign core_rsp_valid = auto_echo ? pv2 : man_valid;
    assign core_rsp_nonce = auto_echo ? pn2 : man_nonce;
    assign core_rsp_hash  = auto_echo ? {NC{echo_hash}} : man_hash;

    // Core model: log every handshake, echo it back three edges later.
    always @(posedge clk_100m) begin
        hs_v = core_req_valid & core_req_ready;
        hs_n = core_req_nonce;
        for (int i = 0; i < NC; i++)
            if (hs_v[i]) begin
                iss_core.push_back(i);
                iss_nonce.push_back(hs_n[i*32 +: 32]);
            end
        #1;
        pv2 = pv1; pn2 = pn1;
        pv1 = pv0; pn1 = pn0;
        pv0 = hs_v; pn0 = hs_n;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (job_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, job_done, 1);
    endtask

    task automatic rsp1(input int core, input logic [31:0] nonce, input logic [31:0] hash);
        man_valid = '0;
        man_valid[core] = 1'b1;
        man_nonce[core*32 +: 32] = nonce;
        man_hash[core*32 +: 32]  = hash;
        tick();
        man_valid = '0;
        exp_hash = exp_hash + 1;
    endtask

    task automatic pop_check(input string name, input logic [31:0] nonce, input int core);
        check({name, "_valid"}, res_valid, 1);
        check({name, "_nonce"}, res_nonce, nonce);
        check({name, "_core"}, res_core, core);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] r, input logic [31:0] t);
        start_nonce = s; nonce_range = r; target = t; job_start = 1'b1;
        tick();
        job_start = 1'b0;
    endtask

    initial begin
        issue_tab[0] = '{0, 32'hFFFF_FFFE};
        issue_tab[1] = '{1, 32'hFFFF_FFFF};
        issue_tab[2] = '{2, 32'h0000_0000};
        issue_tab[3] = '{3, 32'h0000_0001};
        thr_tab[0] = '{8'd100, 1'b0}; thr_tab[1] = '{8'd131, 1'b1};
        thr_tab[2] = '{8'd130, 1'b1}; thr_tab[3] = '{8'd120, 1'b1};
        thr_tab[4] = '{8'd110, 1'b1}; thr_tab[5] = '{8'd109, 1'b0};
        thr_tab[6] = '{8'd110, 1'b0}; thr_tab[7] = '{8'd130, 1'b0};
        thr_tab[8] = '{8'd131, 1'b1}; thr_tab[9] = '{8'd90,  1'b0};
        hit_tab[0] = '{2, 32'h0000_0FFF, 32'h55, 1'b1};
        hit_tab[1] = '{1, 32'h0000_1000, 32'h66, 1'b0};
        hit_tab[2] = '{0, 32'h0000_0000, 32'h77, 1'b1};
        hit_tab[3] = '{3, 32'hFFFF_FFFF, 32'h88, 1'b0};
        hit_tab[4] = '{3, 32'h0000_1001, 32'h99, 1'b0};

        reset = 1'b1; job_start = 1'b0; job_abort = 1'b0; res_ready = 1'b0;
        start_nonce = '0; nonce_range = '0; target = '0; temperature = 8'd25;
        core_req_ready = '0; man_valid = '0; man_nonce = '0; man_hash = '1;
        auto_echo = 1'b0; echo_hash = '1; exp_hash = '0; exp_drop = '0;
        repeat (2) tick();
        check("rst_state", state, 0);
        check("rst_valid", core_req_valid, 0);
        check("rst_req_nonce_zero", core_req_nonce == '0, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_counts", {hash_count, drop_count}, 0);
        check("rst_flags", {busy, throttle, job_done}, 0);
        reset = 1'b0;
        tick();

        // Test 1: wrap-around range of 4 across cores 0..3, no hits
        auto_echo = 1'b1; echo_hash = 32'hFFFF_FFFF; core_req_ready = '1;
        iss_nonce.delete(); iss_core.delete();
        start_job(32'hFFFF_FFFE, 32'd4, 32'h1000);
        check("t1_state_dispatch", state, 1);
        check("t1_valid_cycle1", core_req_valid, 0);
        tick();
        check("t1_valid_cycle2", core_req_valid, 4'b0001);
        check("t1_first_nonce", core_req_nonce[31:0], 32'hFFFF_FFFE);
        wait_done("t1_done", 50);
        exp_hash = exp_hash + 4;
        check("t1_issue_count", iss_nonce.size(), 4);
        for (int k = 0; k < 4 && k < iss_nonce.size(); k++) begin
            check($sformatf("t1_issue_core%0d", k), iss_core[k], issue_tab[k].core);
            check($sformatf("t1_issue_nonce%0d", k), iss_nonce[k], issue_tab[k].nonce);
        end
        tick();
        check("t1_done_pulse", job_done, 0);
        check("t1_hash_count", hash_count, exp_hash);
        check("t1_no_result", res_valid, 0);
        check("t1_idle", busy, 0);
        auto_echo = 1'b0;

        // Test 2a: empty job, abort in same IDLE cycle loses to start
        job_abort = 1'b1;
        start_job(32'h0, 32'd0, 32'h1000);
        job_abort = 1'b0;
        check("t2e_state_c1", state, 1);
        check("t2e_done_c1", job_done, 0);
        tick();
        check("t2e_state_c2", state, 2);
        check("t2e_done_c2", job_done, 0);
        tick();
        check("t2e_done_c3", job_done, 1);
        check("t2e_state_c3", state, 0);
        tick();
        check("t2e_done_c4", job_done, 0);

        // Test 2b: hit detection table, target 0x1000 strict less-than
        for (int k = 0; k < 5; k++) begin
            rsp1(hit_tab[k].core, hit_tab[k].nonce, hit_tab[k].hash);
            check($sformatf("t2_hit%0d_valid", k), res_valid, hit_tab[k].hit);
            if (hit_tab[k].hit) pop_check($sformatf("t2_pop%0d", k), hit_tab[k].nonce, hit_tab[k].core);
        end
        check("t2_hash_count", hash_count, exp_hash);

        // Test 3: overflow of an 8-deep FIFO, then pop-while-full, then order
        exp_pop.delete();
        for (int k = 0; k < 10; k++) begin
            rsp1(1, 32'h100 + k, 32'h0);
            if (k < 8) exp_pop.push_back(32'h100 + k);
        end
        exp_drop = exp_drop + 2;
        check("t3_drop_full", drop_count, exp_drop);
        res_ready = 1'b1;
        rsp1(1, 32'h10A, 32'h0);
        res_ready = 1'b0;
        void'(exp_pop.pop_front());
        exp_pop.push_back(32'h10A);
        check("t3_drop_pop_push", drop_count, exp_drop);
        for (int k = 0; k < 8; k++) pop_check($sformatf("t3_pop%0d", k), exp_pop[k], 1);
        check("t3_empty", res_valid, 0);

        // Test 4: same-cycle hits on cores 0 and 1
        man_valid = 4'b0011;
        man_nonce[31:0] = 32'hA0; man_hash[31:0] = 32'h0;
        man_nonce[63:32] = 32'hA1; man_hash[63:32] = 32'h0;
        tick();
        man_valid = '0;
        exp_hash = exp_hash + 2;
        exp_drop = exp_drop + 1;
        check("t4_drop", drop_count, exp_drop);
        pop_check("t4_pop", 32'hA0, 0);
        check("t4_single", res_valid, 0);
        check("t4_hash_count", hash_count, exp_hash);

        // Test 5a: hysteresis table in IDLE
        for (int k = 0; k < 10; k++) begin
            temperature = thr_tab[k].temp;
            tick();
            check($sformatf("t5_thr_t%0d", thr_tab[k].temp), throttle, thr_tab[k].thr);
        end

        // Test 5b: throttle mid-job stops issue, resumes after cooling
        auto_echo = 1'b1; core_req_ready = '1;
        iss_nonce.delete(); iss_core.delete();
        start_job(32'h1000, 32'd8, 32'h1000);
        tick(); tick();
        temperature = 8'd131;
        tick();
        check("t5_thr_set", throttle, 1);
        tick(); tick();
        n_before = iss_nonce.size();
        check("t5_issued_before", n_before, 3);
        repeat (5) tick();
        check("t5_stalled", iss_nonce.size(), n_before);
        check("t5_no_req", core_req_valid, 0);
        temperature = 8'd120;
        repeat (3) tick();
        check("t5_thr_hold", throttle, 1);
        check("t5_still_stalled", iss_nonce.size(), n_before);
        temperature = 8'd109;
        tick();
        check("t5_thr_clear", throttle, 0);
        wait_done("t5_done", 80);
        exp_hash = exp_hash + 8;
        check("t5_issue_count", iss_nonce.size(), 8);
        for (int k = 0; k < 8 && k < iss_nonce.size(); k++)
            check($sformatf("t5_nonce%0d", k), iss_nonce[k], 32'h1000 + k);
        tick();
        check("t5_hash_count", hash_count, exp_hash);
        auto_echo = 1'b0;

        // Test 6: abort with two outstanding, hit responses discarded
        core_req_ready = 4'b0011;
        iss_nonce.delete(); iss_core.delete();
        start_job(32'h2000, 32'd10, 32'h1000);
        repeat (4) tick();
        check("t6_pending", core_req_valid, 4'b1100);
        check("t6_accepted", iss_nonce.size(), 2);
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        check("t6_withdrawn", core_req_valid, 0);
        check("t6_state_drain", state, 2);
        tick();
        check("t6_wait_rsp", {job_done, state}, 3'b0_10);
        rsp1(0, 32'h2000, 32'h0);
        check("t6_no_push0", res_valid, 0);
        check("t6_no_done_early", job_done, 0);
        rsp1(1, 32'h2001, 32'h0);
        check("t6_no_push1", res_valid, 0);
        wait_done("t6_done", 10);
        check("t6_drop_same", drop_count, exp_drop);
        check("t6_hash_count", hash_count, exp_hash);
        tick();
        check("t6_idle", state, 0);
        rsp1(2, 32'h77, 32'h5);
        pop_check("t6_flag_cleared", 32'h77, 2);

        // Reset mid-job returns everything to the reset state
        core_req_ready = '0;
        start_job(32'h0, 32'd5, 32'h1000);
        repeat (3) tick();
        check("rm_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("rm_state", state, 0);
        check("rm_valid", core_req_valid, 0);
        check("rm_counts", {hash_count, drop_count}, 0);
        check("rm_res", res_valid, 0);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
